div_sched: RTL
==============

# div_sched

Shared signed-divider scheduler. Two requesters compete for one iterative restoring divide datapath (one quotient bit per clock) embedded in this block. The block arbitrates round-robin and converts signed operands to magnitudes. It sequences the n shift-subtract iterations, applies sign correction, and returns the result tagged with the requester id over a valid/ready response port. It sits between the integer-arithmetic clients and the divide datapath, replacing a free-running divider instance per client.

## Interface
- n, 64, operand/result width in bits (two's complement)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_dividend, req0_divisor  in  n  requester 0 operands, signed
- req1_valid, req1_ready, req1_dividend, req1_divisor  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_quotient, rsp_remainder  out  n  signed results
- rsp_div_by_zero  out  1  divisor was zero

## Operation
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: the winner among valid requesters gets reqX_ready=1 combinationally. The loser's ready stays 0.
  - Arbitration: if both are valid, the winner is the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On valid&&ready: latch operands and id, update the pointer, go to LOAD.
- Ready outputs are 0 in every state other than IDLE, and 0 while reset is high.
- LOAD: record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend). Convert both operands to magnitudes as n-bit unsigned values; -2^(n-1) maps to 2^(n-1). Clear the partial remainder (n+1 bits) and the iteration counter.
  - If the divisor is zero, set the div_by_zero flag and go directly to FIX. Otherwise go to RUN.
- RUN: one restoring iteration per cycle:
  - Shift {remainder, quotient} left by 1 and bring in the dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient LSB=1. Otherwise restore and set quotient LSB=0.
  - After exactly n iterations, go to FIX.
- FIX: quotient = sign_q ? -q : q; remainder = sign_r ? -r : r. Quotient truncates toward zero; the remainder takes the dividend's sign. Register the outputs and go to DONE.
- Divide by zero: quotient = all ones, remainder = original dividend, rsp_div_by_zero = 1.
- Overflow: -2^(n-1) / -1 gives quotient -2^(n-1) (wraps) and remainder 0. No flag is raised.
- DONE: rsp_valid=1. All rsp_* outputs are held stable until rsp_valid&&rsp_ready, then the block returns to IDLE. No new request is accepted in that same cycle.
- Reset at any state: abort the operation with no response. State goes to IDLE, the pointer goes to 1, and all rsp_* outputs are cleared.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_div_by_zero=0. Readies are 0 during reset.
- Acceptance edge E0 → LOAD at E1 → n RUN cycles (E2..E(n+1)) → FIX (E(n+2)). rsp_valid rises after E(n+2), i.e. latency is n+2 clocks.
- Divide-by-zero latency: 2 clocks (LOAD → FIX → DONE).
- Minimum issue interval: n+4 clocks. This covers DONE with rsp_ready held high, then one IDLE cycle.
- rsp_ready low stalls indefinitely in DONE. Requests wait and are not dropped. Requester operands need only be stable in the handshake cycle.
- rsp_* outputs may change only on the FIX→DONE edge or at reset.

## Test plan
- n=64, req0 only: 11/3 → q=3, r=2. Then 12/3 → q=4, r=0. Then 15/5 → q=3, r=0. Each rsp_valid arrives 66 clocks after acceptance, rsp_id=0.
- Sign cases, n=64:
  - 100/-99 → q=-1, r=1
  - -100/99 → q=-1, r=-1
  - -100/-99 → q=1, r=-1
  - -11/3 → q=-3, r=-2
  - 11/-3 → q=-3, r=2
  - -11/-3 → q=3, r=-2
- Arbitration: req0 and req1 held valid with different operands for 4 operations → grants alternate 0,1,0,1. rsp_id matches each result, and a loser's ready is never high.
- Divide by zero: 7/0 → rsp_div_by_zero=1, q=all ones, r=7, rsp_valid 2 clocks after acceptance. Next op 9/2 → flag=0, q=4, r=1.
- n=8 overflow and backpressure:
  - -128/-1 → q=-128, r=0.
  - Hold rsp_ready=0 for 20 cycles → outputs stable, both readies 0. Release → one-cycle handshake, then IDLE.
- Reset mid-RUN (iteration 10): reset for 1 clock → no rsp_valid, outputs 0. The next tie is granted to requester 0, and its result is correct.

Source files
------------

// File: rtl/div_sched.sv
// Two-requester round-robin scheduler wrapped around one shared iterative
// restoring signed divider that produces one quotient bit per clock.
module div_sched #(
   parameter int unsigned N = 64
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         req0_valid_i,
   output logic         req0_ready_o,
   input  logic [N-1:0] req0_dividend_i,
   input  logic [N-1:0] req0_divisor_i,
   input  logic         req1_valid_i,
   output logic         req1_ready_o,
   input  logic [N-1:0] req1_dividend_i,
   input  logic [N-1:0] req1_divisor_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic         rsp_id_o,
   output logic [N-1:0] rsp_quotient_o,
   output logic [N-1:0] rsp_remainder_o,
   output logic         rsp_div_by_zero_o
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t       state_q;
   logic         last_q;
   logic         id_q;
   logic [N-1:0] dvd_q;
   logic [N-1:0] dvs_q;
   logic [N-1:0] quo_q;
   logic [N-1:0] mdvs_q;
   logic [N-1:0] rem_q;
   logic [CW-1:0] cnt_q;
   logic         sgn_quo_q;
   logic         sgn_rem_q;
   logic         dbz_q;

   logic         rsp_valid_q;
   logic         rsp_id_q;
   logic [N-1:0] rsp_quo_q;
   logic [N-1:0] rsp_rem_q;
   logic         rsp_dbz_q;

   logic         idle_c;
   logic         gnt0_c;
   logic         gnt1_c;
   logic [N:0]   rem_sh_d;
   logic [N:0]   trial_d;

   function automatic logic [N-1:0] neg(input logic [N-1:0] x);
      return ~x + N'(1);
   endfunction

   // Magnitude as unsigned; the most negative value maps onto 2^(N-1).
   function automatic logic [N-1:0] mag(input logic [N-1:0] x);
      return x[N-1] ? neg(x) : x;
   endfunction

   // On a tie the requester that was not granted last wins.
   assign idle_c       = (state_q == S_IDLE) && !reset_i;
   assign gnt0_c       = req0_valid_i && (!req1_valid_i || last_q);
   assign gnt1_c       = req1_valid_i && (!req0_valid_i || !last_q);
   assign req0_ready_o = idle_c && gnt0_c;
   assign req1_ready_o = idle_c && gnt1_c;

   // One restoring step: shift in the next dividend bit, then trial-subtract.
   assign rem_sh_d = {rem_q, quo_q[N-1]};
   assign trial_d  = rem_sh_d - {1'b0, mdvs_q};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         mdvs_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         sgn_quo_q   <= 1'b0;
         sgn_rem_q   <= 1'b0;
         dbz_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_quo_q   <= '0;
         rsp_rem_q   <= '0;
         rsp_dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt0_c || gnt1_c) begin
                  id_q    <= gnt1_c;
                  last_q  <= gnt1_c;
                  dvd_q   <= gnt1_c ? req1_dividend_i : req0_dividend_i;
                  dvs_q   <= gnt1_c ? req1_divisor_i : req0_divisor_i;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               sgn_quo_q <= dvd_q[N-1] ^ dvs_q[N-1];
               sgn_rem_q <= dvd_q[N-1];
               quo_q     <= mag(dvd_q);
               mdvs_q    <= mag(dvs_q);
               rem_q     <= '0;
               cnt_q     <= '0;
               dbz_q     <= (dvs_q == '0);
               state_q   <= (dvs_q == '0) ? S_FIX : S_RUN;
            end
            S_RUN: begin
               if (!trial_d[N]) begin
                  rem_q <= trial_d[N-1:0];
                  quo_q <= {quo_q[N-2:0], 1'b1};
               end else begin
                  rem_q <= rem_sh_d[N-1:0];
                  quo_q <= {quo_q[N-2:0], 1'b0};
               end
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               rsp_valid_q <= 1'b1;
               rsp_id_q    <= id_q;
               rsp_dbz_q   <= dbz_q;
               if (dbz_q) begin
                  rsp_quo_q <= '1;
                  rsp_rem_q <= dvd_q;
               end else begin
                  rsp_quo_q <= sgn_quo_q ? neg(quo_q) : quo_q;
                  rsp_rem_q <= sgn_rem_q ? neg(rem_q) : rem_q;
               end
               state_q <= S_DONE;
            end
            S_DONE: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_id_o          = rsp_id_q;
   assign rsp_quotient_o    = rsp_quo_q;
   assign rsp_remainder_o   = rsp_rem_q;
   assign rsp_div_by_zero_o = rsp_dbz_q;

endmodule
